// File: rtl/apb_rr_master.sv
// Round-robin APB master: two requesters share one APB slave, one SETUP/ACCESS transfer per grant.
// Optional ACCESS timeout abort is compiled in with `define APB_RR_TIMEOUT_EN.
module apb_rr_master #(
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              sel0, sel1;

`ifdef APB_RR_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;
`endif

  // On a tie the requester that did not win last time is served.
  assign sel0 = req0 & (~req1 | last_q);
  assign sel1 = req1 & (~req0 | ~last_q);

  // Reset gates the grants so they drop asynchronously along with the registered outputs.
  assign gnt0 = (state_q == StIdle) & sel0 & ~PRESET;
  assign gnt1 = (state_q == StIdle) & sel1 & ~PRESET;

  assign PSELx   = (state_q != StIdle);
  assign PENABLE = (state_q == StAccess);
  assign PWRITE  = wr_q;
  assign PADDR   = addr_q;
  assign PWDATA  = wdata_q;
  assign rdata   = rdata_q;
  assign done0   = done0_q;
  assign done1   = done1_q;

`ifdef APB_RR_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
`ifdef APB_RR_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (sel0 || sel1) begin
          owner_d = sel1;
          last_d  = sel1;
          wr_d    = sel1 ? wr1    : wr0;
          addr_d  = sel1 ? addr1  : addr0;
          wdata_d = sel1 ? wdata1 : wdata0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        state_d = StAccess;
`ifdef APB_RR_TIMEOUT_EN
        tmo_d   = 8'd0;
`endif
      end
      StAccess: begin
        if (PREADY) begin
          state_d = StIdle;
          done0_d = ~owner_q;
          done1_d = owner_q;
          if (!wr_q) begin
            rdata_d = PRDATA;
          end
        end
`ifdef APB_RR_TIMEOUT_EN
        else if (tmo_q == TmoLast) begin
          state_d = StIdle;
          done0_d = ~owner_q;
          done1_d = owner_q;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

`ifdef APB_RR_TIMEOUT_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tmo_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`endif

endmodule
